ddr_frame_wr: RTL and testbench
===============================

# ddr_frame_wr

Capture-path write stage that packs the 32-bit GBA pixel stream into 256-bit DDR words and writes one 240x160 frame into DDR, using the same memory layout the DDR read stage consumes: 30 words per line, address step 8, base 0, last word at 38392. It sits between the pixel capture logic and the DDR controller user port. When the final word of a frame is accepted by the controller, it pulses `frame_done`, which drives the read stage's `intr_sig`.

## Interface

Parameters:
- `WORDS_PER_LINE`, 30, number of 256-bit words per line (240 px x 32 bit).
- `LINES`, 160, number of lines per frame.
- `ADDR_STEP`, 8, address increment per word.
- `BASE_ADDR`, 0, address of word 0 of the frame.
- `FIFO_DEPTH`, 16, depth of the internal word queue (power of 2).

Ports:
- `clk` in 1: DDR user clock; pixel inputs are synchronous to it.
- `rst_n` in 1: reset, asynchronous, active-low.
- `init_calib_complete` in 1: DDR controller is ready.
- `capture_en` in 1: frame arm; sampled on `pix_sof`.
- `pix_sof` in 1: single-cycle start-of-frame strobe.
- `pix_valid` in 1: pixel qualifier.
- `pix_data` in 32: pixel data.
- `ddr_cmd_rdy` in 1: controller accepts a command.
- `ddr_wdata_rdy` in 1: controller accepts write data.
- `ddr_cmd` out 3: constant 0 (write).
- `ddr_cmd_en` out 1: command valid.
- `ddr_wr_addr` out 29: word address.
- `ddr_wdata` out 256: write data.
- `ddr_wdata_en` out 1: write data valid.
- `ddr_wdata_end` out 1: equals `ddr_wdata_en` (one beat per burst).
- `ddr_wdata_mask` out 32: constant 0.
- `frame_done` out 1: one-cycle pulse when the last word of the frame is accepted.
- `overflow` out 1: sticky flag for a dropped word; cleared by an accepted `pix_sof`.
- `busy` out 1: high while a frame is active or the queue is non-empty.

## Operation

- **Frame arm.** `pix_sof` with `capture_en=1` clears the packer, sets word counter `wcnt=0`, clears `overflow`, and sets `active`.
  - `pix_sof` with `capture_en=0` clears `active`.
  - `pix_valid` while `active=0` is ignored.
- **Packer.** The 3-bit pixel index `pidx` selects the lane: pixel k goes to bits [32k+31:32k].
  - On the 8th pixel, the packed word, its address `BASE_ADDR + wcnt*ADDR_STEP`, and `last=(wcnt==WORDS_PER_LINE*LINES-1)` are pushed into the queue.
  - `wcnt` increments on each push.
  - After the last word, `active` clears; further pixels are ignored until the next `pix_sof`.
- **`pix_sof` coincident with `pix_valid`.** That pixel becomes pixel 0 of the new frame.
  - A partial word from the previous frame is discarded.
  - Words already queued are still written at their stored addresses.
- **Queue full on push.** The word is dropped and `overflow` is set. `wcnt` still increments, so later words keep correct addresses.
- **Issue FSM, states IDLE and WRITE.**
  - IDLE -> WRITE when the queue is non-empty and `init_calib_complete=1`.
  - In WRITE, `ddr_cmd_en = ddr_wdata_en = ddr_cmd_rdy & ddr_wdata_rdy`. The address and data come from the queue head.
  - Each assertion is an accept: pop the queue. If the popped entry has `last=1`, assert `frame_done` on the next cycle.
  - WRITE -> IDLE when popping the final entry with no same-cycle push, or when `init_calib_complete` drops.
  - Command and data are always issued together in one cycle; a split handshake is never produced.
- **Arithmetic.** `wcnt` is 13 bits (max 4799). The address product fits in 29 bits.

## Timing

- **Reset values:** `ddr_cmd_en=0`, `ddr_wdata_en=0`, `ddr_wdata_end=0`, `ddr_wr_addr=0`, `ddr_wdata=0`, `frame_done=0`, `overflow=0`, `busy=0`, FSM in IDLE, queue empty, `active=0`. `ddr_cmd=0` and `ddr_wdata_mask=0` are constant.
- **Latency:** the 8th pixel is pushed on its clock edge. The earliest DDR accept is 2 cycles later (queue registered, FSM IDLE->WRITE).
- **Throughput:** 1 word per cycle when both ready signals are high. Pixel input is at most 1 pixel per cycle, i.e. 1 word per 8 cycles.
- **`frame_done`:** exactly one cycle, registered, the cycle after the last-word accept.
- **Simultaneous push and pop:** both occur; the queue count is unchanged.
- **Reset mid-frame:** all state is cleared immediately; queued words are lost; no `frame_done`.

## Test plan

- **Full frame, ready always 1.**
  - Stimulus: `capture_en=1`, `pix_sof`, then 38400 pixels with `pix_data` = pixel index.
  - Response: 4800 writes at addresses 0, 8, ... 38392. Word 0 data = {32'd7, ..., 32'd1, 32'd0}.
  - One `frame_done` pulse after the 38392 accept.
- **Backpressure.**
  - Stimulus: `ddr_cmd_rdy` and `ddr_wdata_rdy` randomly toggled at 50%.
  - Response: same 4800 addresses and data in order; no accept when either ready is 0; `overflow=0`.
- **Overflow.**
  - Stimulus: ready held 0 for 200 pixel-words.
  - Response: `FIFO_DEPTH`=16 words are retained, `overflow=1`.
  - After ready goes 1, the retained 16 words are written, followed by subsequent words at their correct addresses (gaps where words were dropped).
- **Mid-frame `pix_sof`.**
  - Stimulus: new `pix_sof` after 13 pixels.
  - Response: word 0 of the old frame is written at address 0; the 5 stray pixels are discarded; the new frame restarts at address 0.
- **Disarmed.**
  - Stimulus: `capture_en=0` at `pix_sof`, then 38400 pixels.
  - Response: no `ddr_cmd_en`; `busy=0`; no `frame_done`.
- **Reset mid-write and calibration gating.**
  - Reset mid-write: `rst_n` low with 10 words queued -> all outputs at reset values next cycle, queue empty.
  - Calibration gating: `init_calib_complete=0` -> no command issued until it rises.

Source files
------------

// File: rtl/ddr_frame_wr.sv
// Packs 32-bit capture pixels into 256-bit words and writes one frame to the DDR user port.
// Words are queued with their address and last-of-frame flag; an IDLE/WRITE FSM drains the queue.
module ddr_frame_wr #(
  parameter int WORDS_PER_LINE = 30,
  parameter int LINES          = 160,
  parameter int ADDR_STEP      = 8,
  parameter int BASE_ADDR      = 0,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init_calib_complete,
  input  logic         capture_en,
  input  logic         pix_sof,
  input  logic         pix_valid,
  input  logic [31:0]  pix_data,
  input  logic         ddr_cmd_rdy,
  input  logic         ddr_wdata_rdy,
  output logic [2:0]   ddr_cmd,
  output logic         ddr_cmd_en,
  output logic [28:0]  ddr_wr_addr,
  output logic [255:0] ddr_wdata,
  output logic         ddr_wdata_en,
  output logic         ddr_wdata_end,
  output logic [31:0]  ddr_wdata_mask,
  output logic         frame_done,
  output logic         overflow,
  output logic         busy
);

  localparam int WORDS = WORDS_PER_LINE * LINES;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int EW    = 1 + 29 + 256;

  typedef enum logic {IDLE, WRITE} state_t;

  logic          active_reg;
  logic [2:0]    pidx_reg;
  logic [12:0]   wcnt_reg;
  logic          overflow_reg;
  logic          frame_done_reg;
  state_t        state_reg, state_next;

  logic          eff_active;
  logic [2:0]    eff_pidx;
  logic [12:0]   eff_wcnt;
  logic          take, push, push_ok, word_last;
  logic [28:0]   push_addr;
  logic [255:0]  push_word;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          full, empty, accept;
  logic [EW-1:0] head;

  // A start-of-frame strobe takes effect in the same cycle, so a coincident pixel lands in lane 0.
  always_comb begin
    eff_active = pix_sof ? capture_en : active_reg;
    eff_pidx   = pix_sof ? 3'd0 : pidx_reg;
    eff_wcnt   = pix_sof ? 13'd0 : wcnt_reg;
    take       = pix_valid & eff_active;
    push       = take & (eff_pidx == 3'd7);
    word_last  = (eff_wcnt == 13'(WORDS - 1));
    push_addr  = 29'(BASE_ADDR) + 29'(eff_wcnt) * 29'(ADDR_STEP);
  end

  // Lanes 0..6 are held in registers; lane 7 comes straight from the 8th pixel.
  // Stale lanes need no clearing: every lane is rewritten before the next push.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      if (gi < 7) begin : g_reg
        logic [31:0] lane_reg;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            lane_reg <= '0;
          else if (take && eff_pidx == 3'(gi))
            lane_reg <= pix_data;
        end
        assign push_word[32*gi +: 32] = lane_reg;
      end else begin : g_top
        assign push_word[32*gi +: 32] = pix_data;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_reg   <= 1'b0;
      pidx_reg     <= 3'd0;
      wcnt_reg     <= 13'd0;
      overflow_reg <= 1'b0;
    end else begin
      if (pix_sof) begin
        active_reg <= capture_en;
        if (capture_en) begin
          pidx_reg     <= 3'd0;
          wcnt_reg     <= 13'd0;
          overflow_reg <= 1'b0;
        end
      end
      if (take) begin
        pidx_reg <= eff_pidx + 3'd1;
        if (push) begin
          // Counter advances even on a drop so later words keep their addresses.
          wcnt_reg <= eff_wcnt + 13'd1;
          if (word_last) active_reg <= 1'b0;
          if (full) overflow_reg <= 1'b1;
        end
      end
    end
  end

  // Word queue: first-word-fall-through, head read directly from the array.
  assign full    = (count_reg == (PW+1)'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push & ~full;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= {word_last, push_addr, push_word};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (accept)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push_ok, accept})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Issue FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Command and data share one handshake, so a split accept can never occur.
  assign accept = (state_reg == WRITE) & init_calib_complete & ddr_cmd_rdy & ddr_wdata_rdy & ~empty;

  // Issue FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (!empty && init_calib_complete) state_next = WRITE;
      WRITE: if (!init_calib_complete || empty ||
                 (accept && count_reg == (PW+1)'(1) && !push_ok))
               state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Issue FSM: outputs
  always_comb begin
    ddr_cmd_en    = accept;
    ddr_wdata_en  = accept;
    ddr_wdata_end = accept;
    ddr_wr_addr   = '0;
    ddr_wdata     = '0;
    if (state_reg == WRITE && !empty) begin
      ddr_wr_addr = head[284:256];
      ddr_wdata   = head[255:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done_reg <= 1'b0;
    else        frame_done_reg <= accept & head[EW-1];
  end

  assign ddr_cmd        = 3'd0;
  assign ddr_wdata_mask = '0;
  assign frame_done     = frame_done_reg;
  assign overflow       = overflow_reg;
  assign busy           = active_reg | ~empty;

endmodule

// File: tb/tb_ddr_frame_wr.sv
// Bench for ddr_frame_wr: a pixel-count frame model plus an expected-write queue checked every cycle,
// with directed scenarios pinned by literal expectations.
module tb_ddr_frame_wr;

  localparam int NWORDS = 4800;
  localparam int QDEPTH = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         init_calib_complete = 1'b0;
  logic         capture_en = 1'b0;
  logic         pix_sof = 1'b0;
  logic         pix_valid = 1'b0;
  logic [31:0]  pix_data = '0;
  logic         ddr_cmd_rdy, ddr_wdata_rdy;
  logic [2:0]   ddr_cmd;
  logic         ddr_cmd_en;
  logic [28:0]  ddr_wr_addr;
  logic [255:0] ddr_wdata;
  logic         ddr_wdata_en, ddr_wdata_end;
  logic [31:0]  ddr_wdata_mask;
  logic         frame_done, overflow, busy;

  logic bp_mode = 1'b0, rdy_fix = 1'b1, rnd_c = 1'b1, rnd_w = 1'b1;
  assign ddr_cmd_rdy   = bp_mode ? rnd_c : rdy_fix;
  assign ddr_wdata_rdy = bp_mode ? rnd_w : rdy_fix;

  always #5 clk = ~clk;

  ddr_frame_wr dut (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .capture_en(capture_en), .pix_sof(pix_sof), .pix_valid(pix_valid), .pix_data(pix_data),
    .ddr_cmd_rdy(ddr_cmd_rdy), .ddr_wdata_rdy(ddr_wdata_rdy), .ddr_cmd(ddr_cmd),
    .ddr_cmd_en(ddr_cmd_en), .ddr_wr_addr(ddr_wr_addr), .ddr_wdata(ddr_wdata),
    .ddr_wdata_en(ddr_wdata_en), .ddr_wdata_end(ddr_wdata_end), .ddr_wdata_mask(ddr_wdata_mask),
    .frame_done(frame_done), .overflow(overflow), .busy(busy)
  );

  typedef struct packed {
    logic         last;
    logic [28:0]  addr;
    logic [255:0] data;
  } ent_t;

  int n_tests = 0, n_fail = 0, cyc = 0;

  // model state
  ent_t        mq[$];
  logic        m_active = 1'b0, m_ovf = 1'b0, m_fd_exp = 1'b0;
  int          m_pix = 0;
  logic [31:0] m_part [8];

  // accept log
  logic [28:0]  acc_addr[$];
  logic [255:0] acc_data[$];
  int           acc_edge[$];
  int           fd_cnt = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_c = 1'($urandom_range(0, 1));
      rnd_w = 1'($urandom_range(0, 1));
    end
  end

  // Compare process: outputs reflect the previous edge; inputs seen now act at the next edge.
  always @(negedge clk) begin
    ent_t e;
    logic fd_next, do_push;
    int   w;
    if (!rst_n) begin
      mq.delete();
      m_active = 1'b0; m_ovf = 1'b0; m_fd_exp = 1'b0; m_pix = 0;
      check_bit("rst_cmd_en", ddr_cmd_en, 1'b0);
      check_bit("rst_wdata_en", ddr_wdata_en, 1'b0);
      check_bit("rst_wdata_end", ddr_wdata_end, 1'b0);
      check_vec("rst_addr", 256'(ddr_wr_addr), '0);
      check_vec("rst_wdata", ddr_wdata, '0);
      check_bit("rst_frame_done", frame_done, 1'b0);
      check_bit("rst_overflow", overflow, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
    end else begin
      check_vec("cmd_const", 256'(ddr_cmd), '0);
      check_vec("mask_const", 256'(ddr_wdata_mask), '0);
      check_bit("wdata_en_eq_cmd_en", ddr_wdata_en, ddr_cmd_en);
      check_bit("wdata_end_eq_en", ddr_wdata_end, ddr_wdata_en);
      check_bit("frame_done", frame_done, m_fd_exp);
      check_bit("overflow", overflow, m_ovf);
      check_bit("busy", busy, m_active || (mq.size() != 0));
      if (frame_done) fd_cnt++;
      fd_next = 1'b0;
      do_push = 1'b0;
      if (ddr_cmd_en) begin
        check_bit("accept_allowed", ddr_cmd_rdy & ddr_wdata_rdy & init_calib_complete, 1'b1);
        if (mq.size() == 0) begin
          check_bit("accept_with_nothing_queued", 1'b1, 1'b0);
        end else begin
          check_vec("wr_addr", 256'(ddr_wr_addr), 256'(mq[0].addr));
          check_vec("wdata", ddr_wdata, mq[0].data);
          fd_next = mq[0].last;
        end
        acc_addr.push_back(ddr_wr_addr);
        acc_data.push_back(ddr_wdata);
        acc_edge.push_back(cyc + 1);
      end
      if (pix_sof) begin
        if (capture_en) begin
          m_active = 1'b1; m_pix = 0; m_ovf = 1'b0;
        end else begin
          m_active = 1'b0;
        end
      end
      if (pix_valid && m_active) begin
        m_part[m_pix % 8] = pix_data;
        m_pix++;
        if (m_pix % 8 == 0) begin
          w = m_pix / 8 - 1;
          e.last = (w == NWORDS - 1);
          e.addr = 29'(w * 8);
          for (int k = 0; k < 8; k++) e.data[32*k +: 32] = m_part[k];
          if (mq.size() >= QDEPTH) m_ovf = 1'b1;
          else do_push = 1'b1;
          if (e.last) m_active = 1'b0;
        end
      end
      if (ddr_cmd_en && mq.size() != 0) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
      m_fd_exp = fd_next;
    end
  end

  task automatic step(input logic s, input logic v, input logic [31:0] d);
    @(posedge clk);
    #1;
    pix_sof = s; pix_valid = v; pix_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 32'd0);
  endtask

  task automatic clear_log();
    acc_addr.delete(); acc_data.delete(); acc_edge.delete(); fd_cnt = 0;
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (mq.size() != 0 && c < budget) begin
      step(1'b0, 1'b0, 32'd0);
      c++;
    end
    check_int("drain_within_budget", mq.size(), 0);
    idle(3);
  endtask

  task automatic disarm();
    capture_en = 1'b0;
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    capture_en = 1'b1;
  endtask

  initial begin
    logic [255:0] w0;
    int push_edge;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);

    // calibration gating
    clear_log();
    capture_en = 1'b1;
    step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32'(i));
    idle(20);
    check_int("gate_no_accepts", acc_addr.size(), 0);
    check_bit("gate_busy", busy, 1'b1);
    init_calib_complete = 1'b1;
    idle(10);
    check_int("gate_accepts_after_calib", acc_addr.size(), 2);
    if (acc_addr.size() == 2) check_int("gate_addr1", int'(acc_addr[1]), 8);
    disarm();

    // full frame, ready always high
    clear_log();
    push_edge = 0;
    step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < NWORDS * 8; i++) begin
      step(1'b0, 1'b1, 32'(i));
      if (i == 7) push_edge = cyc + 1;
    end
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32'(i));
    wait_drain(200);
    for (int k = 0; k < 8; k++) w0[32*k +: 32] = 32'(k);
    check_int("full_accepts", acc_addr.size(), NWORDS);
    if (acc_addr.size() != 0) begin
      check_vec("full_word0_data", acc_data[0], w0);
      check_int("full_first_latency", acc_edge[0] - push_edge, 2);
      check_int("full_last_addr", int'(acc_addr[acc_addr.size()-1]), 38392);
    end
    check_int("full_frame_done_pulses", fd_cnt, 1);
    check_bit("full_busy_after", busy, 1'b0);

    // mid-frame sof coincident with a pixel
    clear_log();
    step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 32'(100 + i));
    step(1'b1, 1'b1, 32'd1000);
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 32'(1000 + i));
    wait_drain(100);
    disarm();
    check_int("mid_accepts", acc_addr.size(), 3);
    if (acc_addr.size() == 3) begin
      check_int("mid_old_addr", int'(acc_addr[0]), 0);
      check_vec("mid_old_lane7", 256'(acc_data[0][255:224]), 256'(107));
      check_int("mid_new_addr0", int'(acc_addr[1]), 0);
      check_vec("mid_new_lane0", 256'(acc_data[1][31:0]), 256'(1000));
      check_int("mid_new_addr1", int'(acc_addr[2]), 8);
      check_vec("mid_new1_lane0", 256'(acc_data[2][31:0]), 256'(1008));
    end

    // random backpressure
    clear_log();
    bp_mode = 1'b1;
    step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 800; i++) step(1'b0, 1'b1, 32'(i * 3 + 5));
    disarm();
    wait_drain(2000);
    bp_mode = 1'b0;
    check_int("bp_accepts", acc_addr.size(), 100);
    if (acc_addr.size() == 100) check_int("bp_last_addr", int'(acc_addr[99]), 792);
    check_bit("bp_no_overflow", overflow, 1'b0);

    // overflow: controller stalled for 200 words
    clear_log();
    rdy_fix = 1'b0;
    step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 1600; i++) step(1'b0, 1'b1, 32'(i));
    step(1'b0, 1'b0, 32'd0);
    check_bit("ovf_set", overflow, 1'b1);
    check_int("ovf_no_accepts", acc_addr.size(), 0);
    rdy_fix = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'(5000 + i));
    wait_drain(200);
    check_int("ovf_accepts", acc_addr.size(), 17);
    if (acc_addr.size() == 17) begin
      check_int("ovf_addr15", int'(acc_addr[15]), 120);
      check_int("ovf_addr16", int'(acc_addr[16]), 1600);
    end
    check_bit("ovf_sticky", overflow, 1'b1);
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    check_bit("ovf_cleared_by_sof", overflow, 1'b0);
    disarm();

    // disarmed frame
    clear_log();
    capture_en = 1'b0;
    step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4000; i++) step(1'b0, 1'b1, 32'(i));
    idle(5);
    check_int("dis_accepts", acc_addr.size(), 0);
    check_bit("dis_busy", busy, 1'b0);
    check_int("dis_frame_done", fd_cnt, 0);
    capture_en = 1'b1;

    // reset with 10 words queued
    clear_log();
    rdy_fix = 1'b0;
    step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 80; i++) step(1'b0, 1'b1, 32'(i));
    idle(3);
    check_bit("rst_pre_busy", busy, 1'b1);
    check_int("rst_pre_queued", mq.size(), 10);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_bit("rst_mid_busy", busy, 1'b0);
    check_bit("rst_mid_cmd_en", ddr_cmd_en, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rdy_fix = 1'b1;
    idle(20);
    check_int("rst_queue_lost", acc_addr.size(), 0);
    check_bit("rst_post_busy", busy, 1'b0);
    check_int("rst_no_frame_done", fd_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
